// File: rtl/reg_file32.sv
// reg_file32: two-read / one-write register file feeding the ALU operands.
// Reads are write-first and land in registered outputs; register 0 always reads zero.
module reg_file32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic                  op_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] regs_r [DEPTH];
    logic [DATA_WIDTH-1:0] op1_r;
    logic [DATA_WIDTH-1:0] op2_r;
    logic                  op_valid_r;
    logic [DATA_WIDTH-1:0] rd1_s;
    logic [DATA_WIDTH-1:0] rd2_s;

    // Register array update; entry 0 is never written so it stays constant zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (write_en && (wr_addr != ZERO_ADDR)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with write-first bypass of same-edge writeback
    always_comb begin
        rd1_s = ZERO_DATA;
        if (rs_addr == ZERO_ADDR) begin
            rd1_s = ZERO_DATA;
        end else if (write_en && (wr_addr == rs_addr)) begin
            rd1_s = wr_data;
        end else begin
            rd1_s = regs_r[rs_addr];
        end
    end

    // Read port 2 with write-first bypass of same-edge writeback
    always_comb begin
        rd2_s = ZERO_DATA;
        if (rt_addr == ZERO_ADDR) begin
            rd2_s = ZERO_DATA;
        end else if (write_en && (wr_addr == rt_addr)) begin
            rd2_s = wr_data;
        end else begin
            rd2_s = regs_r[rt_addr];
        end
    end

    // Operand capture; operands hold between reads so the ALU NOP path sees stable inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1_r      <= ZERO_DATA;
            op2_r      <= ZERO_DATA;
            op_valid_r <= 1'b0;
        end else begin
            op_valid_r <= read_en;
            if (read_en) begin
                op1_r <= rd1_s;
                op2_r <= rd2_s;
            end
        end
    end

    assign op1      = op1_r;
    assign op2      = op2_r;
    assign op_valid = op_valid_r;

endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32: randomized and directed checks of reg_file32 against an array
// model, with expected operands queued at issue and compared by a separate monitor.
module tb_reg_file32;

    logic        clk;
    logic        reset_n;
    logic        read_en;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        write_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        op_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];
    logic [63:0] exp_q [$];
    logic [31:0] last_op1;
    logic [31:0] last_op2;

    reg_file32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .read_en  (read_en),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .write_en (write_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .op1      (op1),
        .op2      (op2),
        .op_valid (op_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-first model: the array after this edge's write is what the read sees.
    task automatic model_edge(input logic re, input int rs, input int rt,
                              input logic we, input int wa, input logic [31:0] wd);
        if (we && wa != 0) model[wa] = wd;
        if (re) exp_q.push_back({(rs == 0) ? 32'd0 : model[rs], (rt == 0) ? 32'd0 : model[rt]});
    endtask

    task automatic step(input logic re, input int rs, input int rt,
                        input logic we, input int wa, input logic [31:0] wd);
        read_en  = re;
        rs_addr  = rs[4:0];
        rt_addr  = rt[4:0];
        write_en = we;
        wr_addr  = wa[4:0];
        wr_data  = wd;
        @(posedge clk);
        model_edge(re, rs, rt, we, wa, wd);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, 0, 32'd0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        exp_q.delete();
        last_op1 = 32'd0;
        last_op2 = 32'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op1"}, op1, 32'd0);
        check({tag, "_op2"}, op2, 32'd0);
        check({tag, "_valid"}, {31'd0, op_valid}, 32'd0);
    endtask

    // Monitor: pops one expectation per valid pulse, otherwise checks that operands hold
    always @(negedge clk) begin
        if (reset_n) begin
            if (op_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, op_valid}, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("op1", op1, e[63:32]);
                    check("op2", op2, e[31:0]);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    check("missing_valid", {31'd0, op_valid}, 32'd1);
                    void'(exp_q.pop_front());
                end
                check("hold_op1", op1, last_op1);
                check("hold_op2", op2, last_op2);
            end
            last_op1 = op1;
            last_op2 = op2;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        read_en = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        write_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        reset_n = 1'b0;
        clear_model();
        #3;
        check_reset_outputs("por");
        #18 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reads right after reset see zeros
        step(1'b1, 5, 31, 1'b0, 0, 32'd0);
        idle();

        // Write then read, followed by an idle hold cycle
        step(1'b0, 0, 0, 1'b1, 3, 32'hDEADBEEF);
        step(1'b0, 0, 0, 1'b1, 4, 32'h00000007);
        step(1'b1, 3, 4, 1'b0, 0, 32'd0);
        idle();
        idle();

        // r0 protection, including same-edge write to r0
        step(1'b0, 0, 0, 1'b1, 0, 32'hFFFFFFFF);
        step(1'b1, 0, 0, 1'b0, 0, 32'd0);
        step(1'b1, 0, 3, 1'b1, 0, 32'hFFFFFFFF);
        idle();

        // Forwarding on both ports, then a plain read of the new value
        step(1'b0, 0, 0, 1'b1, 9, 32'h11111111);
        step(1'b1, 9, 9, 1'b1, 9, 32'h80000000);
        step(1'b1, 9, 4, 1'b0, 0, 32'd0);
        idle();

        // Back-to-back reads
        step(1'b0, 0, 0, 1'b1, 1, 32'd10);
        step(1'b0, 0, 0, 1'b1, 2, 32'd20);
        step(1'b0, 0, 0, 1'b1, 3, 32'd30);
        step(1'b1, 1, 3, 1'b0, 0, 32'd0);
        step(1'b1, 2, 2, 1'b0, 0, 32'd0);
        step(1'b1, 3, 1, 1'b0, 0, 32'd0);
        idle();

        // Asynchronous reset mid-cycle while operands are non-zero
        #2 reset_n = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("async");
        #4 reset_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 3, 9, 1'b0, 0, 32'd0);
        idle();

        // Reset held across an edge carrying a write and a read
        step(1'b0, 0, 0, 1'b1, 7, 32'h0000ABCD);
        read_en = 1'b1; rs_addr = 5'd7; rt_addr = 5'd7;
        write_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00001234;
        @(negedge clk); #1;
        reset_n = 1'b0;
        clear_model();
        @(posedge clk); #1;
        read_en = 1'b0; write_en = 1'b0;
        check_reset_outputs("mid");
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        idle();
        step(1'b1, 7, 0, 1'b0, 0, 32'd0);
        idle();

        // Randomized traffic over a narrow address range to provoke forwarding
        for (int n = 0; n < 400; n++) begin
            int mask;
            mask = (n < 200) ? 7 : 31;
            step(($urandom % 4) != 0, $urandom & mask, $urandom & mask,
                 ($urandom % 2) != 0, $urandom & mask, $urandom);
        end
        idle();
        idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file32.md
# reg_file32

Two-read / one-write register file that sits directly upstream of the 32-bit ALU and supplies its `op1`/`op2` operands. Writeback data is stored in the array. On a read request, the two addressed registers are captured into registered operand outputs one cycle later. A same-cycle write to an addressed register is forwarded to the operand outputs. Register 0 is hardwired to zero.

## Interface
- `DATA_WIDTH`, default 32: register and operand width; must match the ALU operand width.
- `ADDR_WIDTH`, default 5: register address width; array depth is 2^ADDR_WIDTH (32 entries).

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: reset, asynchronous, active-low.
- `read_en`  input  1: read request; operands are captured at this edge.
- `rs_addr`  input  ADDR_WIDTH: source register for `op1`.
- `rt_addr`  input  ADDR_WIDTH: source register for `op2`.
- `write_en`  input  1: writeback strobe.
- `wr_addr`  input  ADDR_WIDTH: writeback destination.
- `wr_data`  input  DATA_WIDTH: writeback value.
- `op1`  output  DATA_WIDTH: registered operand 1, connects to ALU `op1`.
- `op2`  output  DATA_WIDTH: registered operand 2, connects to ALU `op2`.
- `op_valid`  output  1: one-cycle pulse; `op1`/`op2` were updated at the last edge.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH flip-flop array. Entry 0 is not stored and always reads 0.
- Write:
  - At a rising edge with `write_en`=1 and `wr_addr`≠0, entry[`wr_addr`] takes `wr_data`.
  - `write_en`=1 with `wr_addr`=0 has no effect.
- Read:
  - At a rising edge with `read_en`=1, `op1` takes the value of entry[`rs_addr`] and `op2` takes entry[`rt_addr`].
  - `op_valid` is 1 for the following cycle.
- Hold: with `read_en`=0, `op1`/`op2` keep their values and `op_valid`=0. The ALU NOP path relies on stable operands.
- Forwarding (write-first):
  - Applies when `read_en`=1 and `write_en`=1 at the same edge.
  - If `rs_addr`=`wr_addr`≠0, `op1` takes `wr_data` rather than the old entry.
  - Same rule for `rt_addr`/`op2`.
- `rs_addr`=`rt_addr`: both operands get the same value, including forwarding.
- Address 0 read: operand is 0 even if the same-edge write targets 0.
- No arithmetic; values are stored and passed unmodified at full DATA_WIDTH.

## Timing
- Reset (`reset_n` low, asynchronous, takes effect immediately without a clock edge):
  - All array entries = 0, `op1` = 0, `op2` = 0, `op_valid` = 0.
  - Outputs hold these values while `reset_n` is low.
- Reset deassertion: the first edge with `reset_n` high acts normally.
- Reset asserted mid-operation discards any in-flight read or write at that edge. Nothing is written and `op_valid` is 0.
- Read latency: 1 cycle, edge with `read_en` → `op1`/`op2`/`op_valid` valid after that edge.
- Write latency: a write at edge N is visible to a read at edge N (forwarded) and at any later edge (from the array).
- Back-to-back reads on consecutive edges are allowed. `op_valid` stays 1 while `read_en` stays 1.
- No stall or backpressure. The consumer must sample the operands while `op_valid`=1 or before the next read.

## Test plan
- Reset:
  - Drive `reset_n`=0 asynchronously mid-cycle → `op1`=`op2`=0 and `op_valid`=0 immediately.
  - After release, read rs=5, rt=31 → both operands 0 and `op_valid`=1.
- Write then read:
  - Write 0xDEADBEEF to r3, then 0x00000007 to r4.
  - Then `read_en` with rs=3, rt=4 → next cycle `op1`=0xDEADBEEF, `op2`=0x00000007, `op_valid`=1. The following idle cycle has `op_valid`=0 with operands held.
- r0 protection:
  - Write 0xFFFFFFFF to r0, then read rs=0, rt=0 → `op1`=`op2`=0.
  - Same-edge write r0 plus read rs=0 → `op1`=0.
- Forwarding:
  - r9 holds 0x11111111. At one edge, write r9=0x80000000 and read rs=9, rt=9 → both operands 0x80000000.
  - Next read of r9 → 0x80000000.
- Back-to-back:
  - Reads on 3 consecutive edges (rs=1,2,3 holding 10,20,30) → `op1` sequence 10, 20, 30 with `op_valid` high for 3 cycles.
- Reset mid-operation:
  - Assert `reset_n`=0 coincident with a write of 0x1234 to r7 and a read of rs=7.
  - After release, reading r7 → 0, and there is no `op_valid` pulse from the aborted read.
